ula_buffer_saida: RTL and testbench
===================================

// Module: ula_buffer_saida
// PURPOSE
//  Two-entry elastic buffer directly downstream of the ULA. Captures ulaSaida with its destination register
//  and write-enable, and holds them until the writeback stage accepts them. Decouples ULA timing from writeback
//  stalls via a valid/ready handshake. Also produces a zero flag and a 16-bit count of delivered results.
// PARAMETERS
//  LARGURA   32  width of ULA result / saiResultado
//  REG_BITS  5   width of destination-register index
// PORTS
//  clock          in   1         single system clock, all state updates on rising edge
//  reset          in   1         synchronous, active-low reset (sampled on rising clock)
//  limpa          in   1         synchronous flush, drops all buffered entries
//  entValido      in   1         upstream presents a valid ULA result this cycle
//  entPronto      out  1         buffer can accept an entry this cycle
//  ulaSaida       in   LARGURA   ULA result to capture
//  regDestino     in   REG_BITS  destination register of the result
//  escreveReg     in   1         result is to be written to the register file
//  saiValido      out  1         head entry valid
//  saiPronto      in   1         writeback accepts head entry this cycle
//  saiResultado   out  LARGURA   head entry result
//  saiRegDestino  out  REG_BITS  head entry destination register
//  saiEscreveReg  out  1         head entry write-enable
//  saiZero        out  1         1 when saiResultado == 0 (valid only with saiValido)
//  contResultados out  16        number of entries delivered since reset
// BEHAVIOUR
//  - Reset (reset==0 at edge): state VAZIO; saiValido=0, entPronto=1, saiResultado=0, saiRegDestino=0,
//    saiEscreveReg=0, saiZero=1, contResultados=0. Reset overrides limpa and all handshakes, also mid-transfer.
//  - push = entValido & entPronto; pop = saiValido & saiPronto. Transfers complete on the rising edge.
//  - Storage: head register (drives outputs directly, no combinational path from inputs) + one skid register.
//  - States (occupancy): VAZIO(0), UM(1), CHEIO(2). entPronto = (state != CHEIO); saiValido = (state != VAZIO).
//  - VAZIO: push -> head<=input, UM. No push -> stay.
//  - UM: push&!pop -> skid<=input, CHEIO. pop&!push -> VAZIO. push&pop -> head<=input, stay UM. Neither -> stay.
//  - CHEIO: pop -> head<=skid, UM (push impossible, entPronto=0). No pop -> hold all outputs stable.
//  - Latency: entry pushed at edge N is visible on outputs with saiValido=1 immediately after edge N
//    (when VAZIO, or UM with simultaneous pop). Order strictly FIFO; no entry duplicated or lost.
//  - Held outputs stay stable while saiValido=1 and saiPronto=0.
//  - saiZero registered alongside head: (head result == 0). In VAZIO, head fields keep last values.
//  - contResultados increments by 1 on every pop, wraps 16'hFFFF -> 16'h0000; unaffected by limpa.
//  - limpa=1 (reset inactive): state -> VAZIO, concurrent push and pop ignored (no count increment);
//    head fields unchanged.
//  - ulaSaida is unsigned LARGURA bits, stored unmodified; no arithmetic on data.
// TESTING
//  1 reset=0 two cycles -> saiValido=0, entPronto=1, contResultados=0, saiZero=1.
//  2 VAZIO, push ulaSaida=32'h0000_0005 regDestino=3 escreveReg=1, saiPronto=0 -> next cycle saiValido=1,
//    saiResultado=5, saiRegDestino=3, saiZero=0; push 32'h0 -> CHEIO, entPronto=0, outputs still 5.
//  3 From CHEIO, saiPronto=1 two cycles -> pops 5 then 0 (saiZero=1 on second), contResultados=2, VAZIO.
//  4 UM, entValido=1 & saiPronto=1 every cycle for 10 values 1..10 -> outputs 1..10 in order, one per cycle,
//    stays UM, no bubbles.
//  5 CHEIO with limpa=1 and saiPronto=1 -> next cycle saiValido=0, entPronto=1, contResultados unchanged.
//  6 Force contResultados to 16'hFFFF via 65535 pops, one more pop -> 16'h0000; reset=0 while CHEIO -> all
//    reset values next cycle.

Source files
------------

// File: rtl/ula_buffer_saida.sv
// ula_buffer_saida
//   Two-entry elastic buffer placed directly after the ULA. It holds a result,
//   its destination register and its write-enable until writeback accepts them.
//   The head register drives the outputs directly. A skid register absorbs
//   one extra entry, which lets the buffer accept an input in the same cycle
//   that writeback stalls.
// Ports
//   clock, reset (sync, active-low), limpa (sync flush)
//   entValido/entPronto : upstream handshake; ulaSaida/regDestino/escreveReg : entry
//   saiValido/saiPronto : downstream handshake; saiResultado/saiRegDestino/
//   saiEscreveReg/saiZero : head entry; contResultados : delivered-entry count
module ula_buffer_saida #(
  parameter int unsigned LARGURA  = 32,
  parameter int unsigned REG_BITS = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                limpa,
  input  logic                entValido,
  output logic                entPronto,
  input  logic [LARGURA-1:0]  ulaSaida,
  input  logic [REG_BITS-1:0] regDestino,
  input  logic                escreveReg,
  output logic                saiValido,
  input  logic                saiPronto,
  output logic [LARGURA-1:0]  saiResultado,
  output logic [REG_BITS-1:0] saiRegDestino,
  output logic                saiEscreveReg,
  output logic                saiZero,
  output logic [15:0]         contResultados
);

  typedef enum logic [1:0] {VAZIO, UM, CHEIO} estado_t;

  estado_t               r_estado;
  estado_t               w_prox;

  logic [LARGURA-1:0]    r_cabRes;
  logic [REG_BITS-1:0]   r_cabReg;
  logic                  r_cabEsc;
  logic                  r_cabZero;
  logic [LARGURA-1:0]    r_skRes;
  logic [REG_BITS-1:0]   r_skReg;
  logic                  r_skEsc;
  logic [15:0]           r_cont;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_cabDeEnt;
  logic                  w_cabDeSkid;
  logic                  w_carregaSkid;

  assign entPronto      = (r_estado != CHEIO);
  assign saiValido      = (r_estado != VAZIO);
  assign w_push         = entValido & entPronto;
  assign w_pop          = saiValido & saiPronto;

  assign saiResultado   = r_cabRes;
  assign saiRegDestino  = r_cabReg;
  assign saiEscreveReg  = r_cabEsc;
  assign saiZero        = r_cabZero;
  assign contResultados = r_cont;

  always_comb begin
    w_prox        = r_estado;
    w_cabDeEnt    = 1'b0;
    w_cabDeSkid   = 1'b0;
    w_carregaSkid = 1'b0;
    unique case (r_estado)
      VAZIO: begin
        if (w_push) begin
          w_cabDeEnt = 1'b1;
          w_prox     = UM;
        end
      end
      UM: begin
        unique case ({w_push, w_pop})
          2'b10: begin
            w_carregaSkid = 1'b1;
            w_prox        = CHEIO;
          end
          2'b01: w_prox = VAZIO;
          // Head leaves and the new entry replaces it in the same cycle.
          2'b11: w_cabDeEnt = 1'b1;
          default: w_prox = UM;
        endcase
      end
      CHEIO: begin
        if (w_pop) begin
          w_cabDeSkid = 1'b1;
          w_prox      = UM;
        end
      end
      default: w_prox = VAZIO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado  <= VAZIO;
      r_cabRes  <= '0;
      r_cabReg  <= '0;
      r_cabEsc  <= 1'b0;
      r_cabZero <= 1'b1;
      r_skRes   <= '0;
      r_skReg   <= '0;
      r_skEsc   <= 1'b0;
      r_cont    <= '0;
    end else if (limpa) begin
      // Flush drops the entries. Head fields keep their contents, and the
      // count does not change because nothing was delivered.
      r_estado <= VAZIO;
    end else begin
      r_estado <= w_prox;
      if (w_cabDeEnt) begin
        r_cabRes  <= ulaSaida;
        r_cabReg  <= regDestino;
        r_cabEsc  <= escreveReg;
        r_cabZero <= (ulaSaida == '0);
      end else if (w_cabDeSkid) begin
        r_cabRes  <= r_skRes;
        r_cabReg  <= r_skReg;
        r_cabEsc  <= r_skEsc;
        r_cabZero <= (r_skRes == '0);
      end
      if (w_carregaSkid) begin
        r_skRes <= ulaSaida;
        r_skReg <= regDestino;
        r_skEsc <= escreveReg;
      end
      if (w_pop) r_cont <= r_cont + 16'd1;
    end
  end

endmodule

// File: tb/tb_ula_buffer_saida.sv
// tb_ula_buffer_saida
//   Directed stimulus for ula_buffer_saida. Every accepted input pushes its
//   expected entry onto a queue. A monitor on the falling edge pops that queue
//   on each output transfer and compares the result.
module tb_ula_buffer_saida;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        esc;
    logic        zero;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset, limpa, entValido, escreveReg, saiPronto;
  logic        entPronto, saiValido, saiEscreveReg, saiZero;
  logic [31:0] ulaSaida, saiResultado;
  logic [4:0]  regDestino, saiRegDestino;
  logic [15:0] contResultados;

  ent_t sb[$];
  ent_t e_mon;
  int   n_checks = 0;
  int   n_err    = 0;

  ula_buffer_saida #(.LARGURA(32), .REG_BITS(5)) dut (
    .clock(clock), .reset(reset), .limpa(limpa),
    .entValido(entValido), .entPronto(entPronto),
    .ulaSaida(ulaSaida), .regDestino(regDestino), .escreveReg(escreveReg),
    .saiValido(saiValido), .saiPronto(saiPronto),
    .saiResultado(saiResultado), .saiRegDestino(saiRegDestino),
    .saiEscreveReg(saiEscreveReg), .saiZero(saiZero),
    .contResultados(contResultados)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Records the expected entry for an accepted input, then advances one cycle.
  task automatic step();
    ent_t e;
    if (reset && !limpa && entValido && entPronto) begin
      e.res  = ulaSaida;
      e.rd   = regDestino;
      e.esc  = escreveReg;
      e.zero = (ulaSaida == 32'h0);
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    if (!reset || limpa) sb.delete();
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && limpa === 1'b0 && saiValido === 1'b1 && saiPronto === 1'b1) begin
      if (sb.size() == 0) begin
        check("pop_inesperado", 64'd1, 64'd0);
      end else begin
        e_mon = sb.pop_front();
        check("saida", {25'd0, saiResultado, saiRegDestino, saiEscreveReg, saiZero}, {25'd0, e_mon});
      end
    end
  end

  initial begin
    reset = 1'b0; limpa = 1'b0; entValido = 1'b0; saiPronto = 1'b0;
    ulaSaida = '0; regDestino = '0; escreveReg = 1'b0;

    // 1: reset state
    step(); step();
    check("rst_valido", {63'd0, saiValido}, 64'd0);
    check("rst_pronto", {63'd0, entPronto}, 64'd1);
    check("rst_cont",   {48'd0, contResultados}, 64'd0);
    check("rst_zero",   {63'd0, saiZero}, 64'd1);
    reset = 1'b1;

    // 2: one entry in head, then a second one fills the skid while stalled
    entValido = 1'b1; ulaSaida = 32'h5; regDestino = 5'd3; escreveReg = 1'b1;
    step();
    check("t2_valido", {63'd0, saiValido}, 64'd1);
    check("t2_res",    {32'd0, saiResultado}, 64'd5);
    check("t2_rd",     {59'd0, saiRegDestino}, 64'd3);
    check("t2_zero",   {63'd0, saiZero}, 64'd0);
    ulaSaida = 32'h0; regDestino = 5'd7; escreveReg = 1'b0;
    step();
    entValido = 1'b0;
    check("t2_cheio",  {63'd0, entPronto}, 64'd0);
    check("t2_res_h",  {32'd0, saiResultado}, 64'd5);
    step();
    check("t2_estavel", {32'd0, saiResultado}, 64'd5);

    // 3: drain both entries
    saiPronto = 1'b1;
    step();
    check("t3_zero", {63'd0, saiZero}, 64'd1);
    check("t3_cont1", {48'd0, contResultados}, 64'd1);
    step();
    check("t3_cont2", {48'd0, contResultados}, 64'd2);
    check("t3_vazio", {63'd0, saiValido}, 64'd0);
    saiPronto = 1'b0;

    // 4: streaming with simultaneous push and pop, values 1..10
    entValido = 1'b1; ulaSaida = 32'd1; regDestino = 5'd1; escreveReg = 1'b1;
    step();
    saiPronto = 1'b1;
    for (int v = 2; v <= 10; v++) begin
      ulaSaida = v; regDestino = 5'(v);
      step();
      check("t4_um",  {62'd0, saiValido, entPronto}, 64'd3);
      check("t4_res", {32'd0, saiResultado}, 64'(v));
    end
    entValido = 1'b0;
    step();
    check("t4_vazio", {63'd0, saiValido}, 64'd0);
    check("t4_cont",  {48'd0, contResultados}, 64'd12);
    saiPronto = 1'b0;

    // 5: flush from CHEIO with a pending pop
    entValido = 1'b1; ulaSaida = 32'hA; regDestino = 5'd10;
    step();
    ulaSaida = 32'hB; regDestino = 5'd11;
    step();
    entValido = 1'b0;
    check("t5_cheio", {63'd0, entPronto}, 64'd0);
    limpa = 1'b1; saiPronto = 1'b1;
    step();
    limpa = 1'b0; saiPronto = 1'b0;
    check("t5_valido", {63'd0, saiValido}, 64'd0);
    check("t5_pronto", {63'd0, entPronto}, 64'd1);
    check("t5_cont",   {48'd0, contResultados}, 64'd12);
    check("t5_cabeca", {32'd0, saiResultado}, 64'hA);

    // 6: counter wrap, then reset while CHEIO
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("t6_cont0", {48'd0, contResultados}, 64'd0);
    entValido = 1'b1; ulaSaida = 32'd0; regDestino = 5'd1; escreveReg = 1'b1;
    step();
    saiPronto = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      ulaSaida = i;
      step();
    end
    check("t6_ffff", {48'd0, contResultados}, 64'hFFFF);
    entValido = 1'b0;
    step();
    check("t6_wrap", {48'd0, contResultados}, 64'd0);
    saiPronto = 1'b0; entValido = 1'b1; ulaSaida = 32'h11; regDestino = 5'd9;
    step();
    ulaSaida = 32'h22;
    step();
    entValido = 1'b0;
    check("t6_cheio", {63'd0, entPronto}, 64'd0);
    reset = 1'b0; saiPronto = 1'b1;
    step();
    check("t6_rst_valido", {63'd0, saiValido}, 64'd0);
    check("t6_rst_pronto", {63'd0, entPronto}, 64'd1);
    check("t6_rst_res",    {32'd0, saiResultado}, 64'd0);
    check("t6_rst_rd",     {59'd0, saiRegDestino}, 64'd0);
    check("t6_rst_esc",    {63'd0, saiEscreveReg}, 64'd0);
    check("t6_rst_zero",   {63'd0, saiZero}, 64'd1);
    check("t6_rst_cont",   {48'd0, contResultados}, 64'd0);
    check("sb_vazio", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
